// File: rtl/midi_spi_bridge_if.sv
// Board-side pins of the MIDI/SPI bridge: SPI slave port, MIDI input and interrupt.
interface midi_spi_bridge_if;
  logic spi_sck;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;
  logic midi_in;
  logic irq;

  modport slave (
    input  spi_sck,
    input  spi_ss,
    input  spi_mosi,
    input  midi_in,
    output spi_miso,
    output irq
  );

  modport master (
    output spi_sck,
    output spi_ss,
    output spi_mosi,
    output midi_in,
    input  spi_miso,
    input  irq
  );
endinterface

// File: rtl/midi_spi_bridge.sv
// MIDI UART receiver with a register bank, read and written by an SPI master
// through a command/data byte bridge on a single-cycle internal bus.
module midi_spi_bridge #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  midi_spi_bridge_if.slave  bus
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);

  localparam logic [7:0] ADDR_RX_DATA = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_CTRL    = 8'h02;

  typedef enum logic [1:0] {BR_CMD, BR_CMD_EXEC, BR_DATA, BR_DATA_EXEC} br_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] sck_sync, ss_sync, mosi_sync, midi_sync;
  logic       sck_d, ss_d, midi_d;
  logic       sck_s, ss_s, mosi_s, midi_s;
  logic       sck_fall, ss_rise, midi_fall;

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      midi_sync <= 2'b11;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
      midi_d    <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], bus.spi_sck};
      ss_sync   <= {ss_sync[0], bus.spi_ss};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
      midi_sync <= {midi_sync[0], bus.midi_in};
      sck_d     <= sck_sync[1];
      ss_d      <= ss_sync[1];
      midi_d    <= midi_sync[1];
    end
  end

  assign sck_s     = sck_sync[1];
  assign ss_s      = ss_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign midi_s    = midi_sync[1];
  assign sck_fall  = sck_d & ~sck_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign midi_fall = midi_d & ~midi_s;

  // ---------------------------------------------------------------- bus
  logic       bus_stb;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  // ---------------------------------------------------------------- SPI bridge
  br_state_t  br_state, br_state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] tx, tx_n;
  logic       we_q, we_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] data_q, data_n;
  logic       miso, miso_n;
  logic       byte_done;
  logic [7:0] byte_val;

  // Bridge state and SPI shift registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      br_state <= BR_CMD;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      tx       <= 8'h00;
      we_q     <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      miso     <= 1'b0;
    end else begin
      br_state <= br_state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
      miso     <= miso_n;
    end
  end

  // Bit capture, command/data sequencing and bus access; MISO indexes TX by bit count.
  always_comb begin
    br_state_n = br_state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx;
    we_n       = we_q;
    addr_n     = addr_q;
    data_n     = data_q;
    byte_done  = 1'b0;
    byte_val   = {shift[6:0], mosi_s};
    bus_stb    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = addr_q;
    bus_wdata  = data_q;

    if (sck_fall && !ss_s) begin
      shift_n   = byte_val;
      bit_cnt_n = bit_cnt + 3'd1;
      byte_done = (bit_cnt == 3'd7);
    end else if (ss_rise) begin
      shift_n   = 8'h00;
      bit_cnt_n = 3'd0;
    end

    case (br_state)
      BR_CMD: begin
        if (byte_done) begin
          we_n       = byte_val[7];
          addr_n     = {1'b0, byte_val[6:0]};
          br_state_n = BR_CMD_EXEC;
        end
      end
      BR_CMD_EXEC: begin
        if (!we_q) begin
          bus_stb = 1'b1;
          tx_n    = bus_rdata;
        end else begin
          tx_n    = 8'h00;
        end
        br_state_n = BR_DATA;
      end
      BR_DATA: begin
        if (byte_done) begin
          data_n     = byte_val;
          br_state_n = BR_DATA_EXEC;
        end
      end
      BR_DATA_EXEC: begin
        if (we_q) begin
          bus_stb = 1'b1;
          bus_we  = 1'b1;
        end
        tx_n       = 8'h00;
        br_state_n = BR_CMD;
      end
      default: br_state_n = BR_CMD;
    endcase

    miso_n = tx_n[~bit_cnt_n];
  end

  assign bus.spi_miso = miso;

  // ---------------------------------------------------------------- MIDI receiver
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_sh, rx_sh_n;
  logic             rx_done;
  logic             rx_ferr;
  logic             rx_enable;

  // Receiver state, bit timer and data shift register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h00;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  // Start-bit qualification, mid-bit sampling and stop-bit check.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;

    if (!rx_enable) begin
      rx_state_n = RX_IDLE;
      rx_cnt_n   = '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (midi_fall) begin
            rx_state_n = RX_START;
            rx_cnt_n   = '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
            rx_cnt_n   = '0;
            rx_bit_n   = 3'd0;
            rx_state_n = midi_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_n = rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_n = '0;
            rx_sh_n  = {midi_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            else                rx_bit_n   = rx_bit + 3'd1;
          end else begin
            rx_cnt_n = rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_n = '0;
            if (midi_s) begin
              rx_done    = 1'b1;
              rx_state_n = RX_IDLE;
            end else begin
              rx_ferr    = 1'b1;
              rx_state_n = RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt_n = rx_cnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (midi_s) rx_state_n = RX_IDLE;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- register bank
  logic [7:0] rx_data;
  logic       rx_valid, rx_valid_n;
  logic       overrun;
  logic       framing_err;
  logic       irq;
  logic       rd_rx;

  assign rd_rx = bus_stb && !bus_we && (bus_addr == ADDR_RX_DATA);

  // Combinational read mux for the single-cycle bus.
  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      ADDR_RX_DATA: bus_rdata = rx_data;
      ADDR_STATUS:  bus_rdata = {5'b0, framing_err, overrun, rx_valid};
      ADDR_CTRL:    bus_rdata = {7'b0, rx_enable};
      default:      bus_rdata = 8'h00;
    endcase
  end

  // A completing byte takes priority over a simultaneous RX_DATA read.
  always_comb begin
    rx_valid_n = rx_valid;
    if (rd_rx)   rx_valid_n = 1'b0;
    if (rx_done) rx_valid_n = 1'b1;
  end

  // Register updates from bus writes and receiver events; set beats clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      rx_enable   <= 1'b1;
      irq         <= 1'b0;
    end else begin
      rx_valid <= rx_valid_n;
      irq      <= rx_valid_n;
      if (bus_stb && bus_we && bus_addr == ADDR_STATUS) begin
        if (bus_wdata[1]) overrun     <= 1'b0;
        if (bus_wdata[2]) framing_err <= 1'b0;
      end
      if (bus_stb && bus_we && bus_addr == ADDR_CTRL) rx_enable <= bus_wdata[0];
      if (rx_done) begin
        rx_data <= rx_sh;
        if (rx_valid) overrun <= 1'b1;
      end
      if (rx_ferr) framing_err <= 1'b1;
    end
  end

  assign bus.irq = irq;

endmodule

// File: tb/tb_midi_spi_bridge.sv
// Randomized scoreboard bench for midi_spi_bridge: a passive SPI monitor
// compares every MISO byte against expectations from a register-level model.
module tb_midi_spi_bridge;

  localparam int unsigned CLKS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  midi_spi_bridge_if bus();

  midi_spi_bridge #(.CLKS_PER_BIT(CLKS)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the register map
  logic [7:0] m_rx;
  logic       m_valid, m_ovr, m_ferr, m_en;
  logic [7:0] exp_q[$];

  function automatic void m_reset();
    m_rx = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_en = 1'b1;
  endfunction

  function automatic logic [7:0] m_read(input logic [6:0] a);
    logic [7:0] r;
    case (a)
      7'h00: begin r = m_rx; m_valid = 1'b0; end
      7'h01: r = {5'b0, m_ferr, m_ovr, m_valid};
      7'h02: r = {7'b0, m_en};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'h01) begin
      if (d[1]) m_ovr  = 1'b0;
      if (d[2]) m_ferr = 1'b0;
    end else if (a == 7'h02) begin
      m_en = d[0];
    end
  endfunction

  function automatic void m_midi(input logic [7:0] b, input logic stop);
    if (!m_en) return;
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_rx    = b;
      m_valid = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endfunction

  function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endfunction

  // Passive SPI monitor: assemble MISO bytes seen at master falling edges
  logic [7:0] mon_byte = 8'h00;
  int         mon_cnt  = 0;

  always @(negedge bus.spi_sck) begin
    if (bus.spi_ss === 1'b0) begin
      mon_byte = {mon_byte[6:0], bus.spi_miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: got %02h expected none", mon_byte);
        end else begin
          check8("miso_byte", mon_byte, exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge bus.spi_ss) mon_cnt = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master drives MOSI at SCK rise, so it is stable across the sampling fall
  task automatic spi_bits(input logic [7:0] b, input int nbits, input int h);
    for (int i = 7; i > 7 - nbits; i--) begin
      wait_clk(h);
      bus.spi_mosi = b[i];
      bus.spi_sck  = 1'b1;
      wait_clk(h);
      bus.spi_sck  = 1'b0;
    end
    wait_clk(3);
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input logic [7:0] data);
    int h;
    bit same;
    h    = $urandom_range(4, 8);
    same = 1'($urandom_range(0, 1));
    exp_q.push_back(8'h00);
    if (!cmd[7]) exp_q.push_back(m_read(cmd[6:0]));
    else begin
      exp_q.push_back(8'h00);
      m_write(cmd[6:0], data);
    end
    bus.spi_ss = 1'b0;
    wait_clk(4);
    spi_bits(cmd, 8, h);
    if (same) wait_clk(8);
    else begin
      bus.spi_ss = 1'b1;
      wait_clk(10);
      bus.spi_ss = 1'b0;
      wait_clk(4);
    end
    spi_bits(data, 8, h);
    bus.spi_ss = 1'b1;
    wait_clk(10);
  endtask

  task automatic midi_send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    bus.midi_in = 1'b0;
    wait_clk(CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.midi_in = b[i];
      wait_clk(CLKS);
    end
    bus.midi_in = stop;
    wait_clk(CLKS);
    bus.midi_in = 1'b1;
    wait_clk(3 * CLKS);
    m_midi(b, stop);
  endtask

  task automatic check_irq(input string name);
    check8(name, {7'b0, bus.irq}, {7'b0, m_valid});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb, rd;
    int op;
    bus.spi_ss   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.midi_in  = 1'b1;
    m_reset();
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);

    // Reset state
    check8("reset_miso", {7'b0, bus.spi_miso}, 8'h00);
    check_irq("reset_irq");
    spi_txn(8'h00, 8'h00);
    spi_txn(8'h00, 8'h00);
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h02, 8'h00);

    // Single byte, status, then consume
    midi_send(8'h90, 1'b1);
    check_irq("irq_after_90");
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h00, 8'h00);
    check_irq("irq_after_read");
    spi_txn(8'h01, 8'h00);

    // Overrun and W1C
    midi_send(8'h3C, 1'b1);
    midi_send(8'h7F, 1'b1);
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h81, 8'h02);
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h00, 8'h00);

    // Framing error
    midi_send(8'h55, 1'b0);
    check_irq("irq_after_ferr");
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h00, 8'h00);
    spi_txn(8'h81, 8'h04);
    spi_txn(8'h01, 8'h00);

    // Receiver disabled
    spi_txn(8'h82, 8'h00);
    midi_send(8'h40, 1'b1);
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h02, 8'h00);
    spi_txn(8'h82, 8'h01);
    spi_txn(8'h02, 8'h00);

    // Unmapped address: write ignored, read zero
    spi_txn(8'hA5, 8'hFF);
    spi_txn(8'h25, 8'h00);

    // SS abort after four bits
    midi_send(8'h5A, 1'b1);
    bus.spi_ss = 1'b0;
    wait_clk(4);
    spi_bits(8'hF3, 4, 5);
    bus.spi_ss = 1'b1;
    wait_clk(10);
    spi_txn(8'h00, 8'h00);
    check_irq("irq_after_abort_read");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      rb = 8'($urandom);
      case (op)
        0, 1: midi_send(rb, ($urandom_range(0, 4) != 0));
        2:    spi_txn({1'b0, 7'($urandom_range(0, 4))}, rb);
        3:    spi_txn(8'h81, rb);
        4: begin
          rd = {rb[7:1], 1'($urandom_range(0, 3) != 0)};
          spi_txn(8'h82, rd);
        end
        default: spi_txn(8'h00, rb);
      endcase
      check_irq("irq_random");
    end

    // Reset in the middle of a MIDI byte
    spi_txn(8'h82, 8'h01);
    midi_send(8'h11, 1'b1);
    check_irq("irq_before_reset");
    @(negedge clk);
    bus.midi_in = 1'b0;
    wait_clk(CLKS + 20);
    rst = 1'b1;
    bus.midi_in = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    m_reset();
    wait_clk(10);
    check_irq("irq_after_reset");
    spi_txn(8'h01, 8'h00);
    spi_txn(8'h00, 8'h00);
    spi_txn(8'h02, 8'h00);

    wait_clk(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
